// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_pkg
// Brief    : Shared frame-buffer constants, arbiter state, client/tag types.
// Revision : 1.0
// ============================================================================
package fb_pkg;

    localparam int FB_AW    = 19;
    localparam int FB_DW    = 8;
    localparam int FB_DEPTH = 640 * 480;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    typedef logic [1:0] client_idx_t;

    typedef struct packed {
        logic        vld;
        client_idx_t cli;
    } tag_t;

    function automatic client_idx_t next_client(input client_idx_t c, input int n);
        if (int'(c) >= n - 1)
            return '0;
        return c + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_porta_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fb_porta_arbiter_if
// Brief    : Client command/response bundle plus BRAM port A pins.
// Revision : 1.0
// ============================================================================
interface fb_porta_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int AW    = fb_pkg::FB_AW,
    parameter int DW    = fb_pkg::FB_DW
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    lock;
    logic [N_REQ-1:0]    we;
    logic [N_REQ*AW-1:0] addr;
    logic [N_REQ*DW-1:0] wdata;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    rvalid;
    logic [DW-1:0]       rdata;
    logic                mem_en;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_din;
    logic [DW-1:0]       mem_dout;
    logic                busy;

    modport slave (
        input  req, lock, we, addr, wdata, mem_dout,
        output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_din, busy
    );

    modport master (
        output req, lock, we, addr, wdata, mem_dout,
        input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_din, busy
    );
endinterface
`default_nettype wire

// File: rtl/fb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : fb_rr_pick
// Brief    : Combinational round-robin pick: first requester at/after i_ptr.
// Revision : 1.0
// ============================================================================
module fb_rr_pick
    import fb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  wire logic [N_REQ-1:0] i_req,
    input  wire client_idx_t      i_ptr,
    output logic [N_REQ-1:0]      o_pick,
    output logic                  o_valid
);

    logic [N_REQ-1:0] w_rot;
    logic [N_REQ-1:0] w_rot_pick;

    // Rotate so i_ptr sits at bit 0, isolate the lowest set bit, rotate back.
    assign w_rot      = N_REQ'({i_req, i_req} >> i_ptr);
    assign w_rot_pick = w_rot & (~w_rot + N_REQ'(1));
    assign o_pick     = N_REQ'(({w_rot_pick, w_rot_pick} << i_ptr) >> N_REQ);
    assign o_valid    = |i_req;

endmodule
`default_nettype wire

// File: rtl/fb_porta_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_porta_arbiter
// Brief    : Round-robin, lockable arbiter owning frame-buffer BRAM port A.
//            Optional statistics counters under `FB_ARB_STATS_EN.
// Revision : 1.0
// ============================================================================
module fb_porta_arbiter
    import fb_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int AW       = FB_AW,
    parameter int DW       = FB_DW,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fb_porta_arbiter_if.slave  bus
`ifdef FB_ARB_STATS_EN
    ,
    input  wire logic          stat_clr,
    output logic [N_REQ*16-1:0] stat_gnt_cnt,
    output logic [7:0]         stat_max_wait
`endif
);

    arb_state_t       r_state, w_state_nxt;
    client_idx_t      r_owner, w_owner_nxt;
    client_idx_t      r_rr_ptr, w_rr_ptr_nxt;
    logic [7:0]       r_lock_cnt, w_lock_cnt_nxt;

    client_idx_t      w_ptr, w_sel;
    logic [N_REQ-1:0] w_pick, w_gnt, w_owner_oh;
    logic             w_pick_valid, w_acc, w_cap, w_other, w_rearb;
    logic             w_sel_we, w_sel_lock;
    logic [AW-1:0]    w_sel_addr;
    logic [DW-1:0]    w_sel_din;

    tag_t             r_tag [RD_LAT+1];
    logic             w_tag_busy;
    logic [N_REQ-1:0] r_rvalid;
    logic [DW-1:0]    r_rdata;
    logic             r_mem_en, r_mem_we;
    logic [AW-1:0]    r_mem_addr;
    logic [DW-1:0]    r_mem_din;

    fb_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_req   (bus.req),
        .i_ptr   (w_ptr),
        .o_pick  (w_pick),
        .o_valid (w_pick_valid)
    );

    // Re-arbitration happens in the same cycle the owner lets go.
    always_comb begin
        w_owner_oh = N_REQ'(1) << r_owner;
        w_cap      = (r_lock_cnt == 8'(LOCK_MAX));
        w_other    = |(bus.req & ~w_owner_oh);
        w_rearb    = (r_state == ARB_IDLE) || !(|(bus.req & w_owner_oh)) || (w_cap && w_other);
        w_ptr      = (r_state == ARB_IDLE) ? r_rr_ptr : next_client(r_owner, N_REQ);
        w_gnt      = w_rearb ? (w_pick_valid ? w_pick : '0) : w_owner_oh;
        w_acc      = |w_gnt;
        w_sel_we   = |(bus.we & w_gnt);
        w_sel_lock = |(bus.lock & w_gnt);
        w_sel      = '0;
        w_sel_addr = '0;
        w_sel_din  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_gnt[k]) begin
                w_sel      = client_idx_t'(k);
                w_sel_addr = bus.addr[k*AW +: AW];
                w_sel_din  = bus.wdata[k*DW +: DW];
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_lock_cnt_nxt = r_lock_cnt;
        if (r_state == ARB_OWNED && w_rearb)
            w_rr_ptr_nxt = next_client(r_owner, N_REQ);
        if (w_acc) begin
            if (w_sel_lock) begin
                w_state_nxt = ARB_OWNED;
                w_owner_nxt = w_sel;
                if (r_state == ARB_OWNED && !w_rearb)
                    w_lock_cnt_nxt = w_cap ? 8'd1 : r_lock_cnt + 8'd1;
                else
                    w_lock_cnt_nxt = 8'd1;
            end else begin
                w_state_nxt    = ARB_IDLE;
                w_rr_ptr_nxt   = next_client(w_sel, N_REQ);
                w_lock_cnt_nxt = '0;
            end
        end else if (r_state == ARB_OWNED) begin
            w_state_nxt    = ARB_IDLE;
            w_lock_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    // Tag pipe is one stage longer than RD_LAT to cover the mem_addr register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= RD_LAT; k++)
                r_tag[k] <= '0;
            r_rvalid   <= '0;
            r_rdata    <= '0;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
        end else begin
            r_tag[0] <= '{vld: w_acc && !w_sel_we, cli: w_sel};
            for (int k = 1; k <= RD_LAT; k++)
                r_tag[k] <= r_tag[k-1];
            r_rvalid <= r_tag[RD_LAT].vld ? (N_REQ'(1) << r_tag[RD_LAT].cli) : '0;
            r_rdata  <= bus.mem_dout;
            r_mem_en <= w_acc;
            r_mem_we <= w_acc && w_sel_we;
            if (w_acc) begin
                r_mem_addr <= w_sel_addr;
                r_mem_din  <= w_sel_din;
            end
        end
    end

    always_comb begin
        w_tag_busy = 1'b0;
        for (int k = 0; k <= RD_LAT; k++)
            w_tag_busy = w_tag_busy | r_tag[k].vld;
    end

    assign bus.gnt      = w_gnt;
    assign bus.rvalid   = r_rvalid;
    assign bus.rdata    = r_rdata;
    assign bus.mem_en   = r_mem_en;
    assign bus.mem_we   = r_mem_we;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_din  = r_mem_din;
    assign bus.busy     = (r_state == ARB_OWNED) || w_tag_busy || r_mem_en;

`ifdef FB_ARB_STATS_EN
    logic [7:0] w_wait_all [N_REQ];
    logic [7:0] r_max_wait, w_wait_peak;

    for (genvar g = 0; g < N_REQ; g++) begin : g_stats
        logic [15:0] r_gnt_cnt;
        logic [7:0]  r_wait;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_gnt_cnt <= '0;
                r_wait    <= '0;
            end else if (stat_clr) begin
                r_gnt_cnt <= '0;
                r_wait    <= '0;
            end else begin
                if (w_gnt[g] && r_gnt_cnt != 16'hFFFF)
                    r_gnt_cnt <= r_gnt_cnt + 16'd1;
                if (bus.req[g] && !w_gnt[g]) begin
                    if (r_wait != 8'hFF)
                        r_wait <= r_wait + 8'd1;
                end else begin
                    r_wait <= '0;
                end
            end
        end
        assign stat_gnt_cnt[g*16 +: 16] = r_gnt_cnt;
        assign w_wait_all[g]            = r_wait;
    end

    always_comb begin
        w_wait_peak = r_max_wait;
        for (int k = 0; k < N_REQ; k++)
            if (w_wait_all[k] > w_wait_peak)
                w_wait_peak = w_wait_all[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_max_wait <= '0;
        else if (stat_clr)
            r_max_wait <= '0;
        else
            r_max_wait <= w_wait_peak;
    end

    assign stat_max_wait = r_max_wait;
`endif

endmodule
`default_nettype wire

// File: doc/fb_porta_arbiter.md
Name: fb_porta_arbiter

Overview:
- Shares frame-buffer port A (19-bit address, 8-bit data, 100 MHz domain) between N_REQ requesters, e.g. the pattern/memory-write controller and a scroll/clear engine.
- Uses a per-beat req/gnt handshake with round-robin fairness.
- Supports locked bursts, capped by a burst limit.
- Routes read data back to the issuing client via a latency-matched tag pipe.
- Owns the only connection to the BRAM port A pins.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- AW, 19, address width.
- DW, 8, data width.
- RD_LAT, 1, BRAM read latency in cycles from address sample to douta valid (1..3).
- LOCK_MAX, 16, maximum consecutive grants to one locked client before forced rotation (2..255).

Ports:
- clk  in  1  port A clock (clk_100).
- rst  in  1  reset, asynchronous, active-high.
- req  in  N_REQ  per-client command request; command fields must be stable while req=1.
- lock  in  N_REQ  per-client burst hold; meaningful only while that client owns the port.
- we  in  N_REQ  per-client write (1) / read (0).
- addr  in  N_REQ*AW  per-client address, client i at [i*AW +: AW].
- wdata  in  N_REQ*DW  per-client write data.
- gnt  out  N_REQ  one-hot; command accepted in any cycle where req[i] & gnt[i].
- rvalid  out  N_REQ  one-hot pulse; read data for client i is valid on rdata.
- rdata  out  DW  registered copy of mem_dout.
- mem_en  out  1  to BRAM ena.
- mem_we  out  1  to BRAM wea.
- mem_addr  out  AW  to BRAM addra.
- mem_din  out  DW  to BRAM dina.
- mem_dout  in  DW  from BRAM douta.
- busy  out  1  high while any command is in flight or the port is owned.

Behaviour:
- Reset values: gnt=0, rvalid=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_din=0, busy=0, rr_ptr=0, state=IDLE, lock_cnt=0, tag pipe cleared.
- gnt is combinational from req and the registered state, so a grant is given in the same cycle as the request.
- At most one gnt bit is high per cycle. gnt[i] is never high unless req[i]=1.
- Memory signals are registered at the accepting edge:
  - mem_en=1, mem_we=we[i], mem_addr, mem_din.
  - In the cycle after the accepting edge with no new acceptance, mem_en=0 and mem_we=0.
- Read latency: a read accepted in cycle t gives rvalid[i]=1 with rdata valid in cycle t+1+RD_LAT+1; the extra stage is the rdata register.
  - The tag pipe carries a {valid,client} pair in a shift register of depth RD_LAT+1.
- Writes produce no rvalid. Reads and writes may be issued back-to-back every cycle (throughput 1/cycle).
- State machine:
  - IDLE: the first requesting client at or after rr_ptr (circular) is granted. If lock[i]=1 at acceptance, go to OWNED(i) with lock_cnt=1. Otherwise set rr_ptr=(i+1) mod N_REQ and stay in IDLE.
  - OWNED(i):
    - If req[i]=1, lock_cnt<LOCK_MAX and lock[i]=1 at the previous acceptance, only client i may be granted. Each accept does lock_cnt+1.
    - Exit to IDLE with rr_ptr=(i+1) mod N_REQ when any of these holds:
      - an accept has lock[i]=0;
      - req[i]=0 for one cycle (no grant that cycle);
      - lock_cnt reaches LOCK_MAX and another client is requesting.
    - If lock_cnt reaches LOCK_MAX and no other client is requesting, lock_cnt reloads to 1 and i keeps ownership.
- Simultaneous events:
  - The exit decision and the IDLE re-arbitration happen in the same cycle; there is no bubble cycle on hand-off.
- Reset mid-burst or mid-read:
  - In-flight reads are dropped; no rvalid is produced after reset.
  - Requesters must reissue.
- busy = (state==OWNED) | any tag-pipe valid | mem_en.
- Addresses are passed through unchecked; range limits are the requesters' responsibility.

Optional Feature:
- Macro: FB_ARB_STATS_EN.
- When defined, adds:
  - output stat_gnt_cnt, N_REQ*16 bits: saturating per-client grant counters.
  - output stat_max_wait, 8 bits: largest number of consecutive cycles any req was high without a grant, saturating at 255.
  - input stat_clr, 1 bit: synchronous clear of all counters. Also cleared by rst.
- When undefined, these ports and counters are absent and the arbitration logic is unchanged.

Decomposition:
- Shared package fb_pkg holds:
  - FB_AW=19, FB_DW=8, FB_DEPTH=640*480.
  - The arbiter state enum {ARB_IDLE, ARB_OWNED}.
  - A client-index typedef.
- One sub-module: fb_rr_pick. It is purely combinational: given req and rr_ptr, it returns a one-hot pick plus a valid flag, and is reused in both states.

Test Plan:
1. Single read: client0 reads addr 19'h00010 with BRAM preloaded 8'hA5 -> gnt[0] same cycle; mem_addr=0x00010 next cycle; rvalid[0]=1 with rdata=8'hA5 exactly 3 cycles after acceptance (RD_LAT=1); rvalid[1] never asserts.
2. Round-robin: both clients hold req with lock=0 for 8 cycles -> grants alternate 0,1,0,1…; 4 each; no idle cycle.
3. Lock cap: client0 lock=1 and req=1 continuously, client1 req=1, LOCK_MAX=16 -> 16 consecutive gnt[0], then gnt[1] on the very next cycle, then back to client0.
4. Lock with no contender: client0 locked for 40 beats, client1 idle -> 40 consecutive grants to client0 with no gaps.
5. Read/write interleave: client1 writes 8'h3C to 0x12C00, client0 reads the same address the next cycle -> client0 rvalid with rdata=8'h3C (write-first ordering preserved).
6. Reset mid-read: assert rst 1 cycle after a read is accepted -> all outputs return to 0 immediately; no rvalid afterwards; the first post-reset request from client1 is granted (rr_ptr=0, client0 idle).
